// File: rtl/keccak_pkg.sv
// Shared Keccak definitions used by the pad/block feeder and the permutation stage.
package keccak_pkg;

  localparam int NLANES = 25;
  localparam int LANE_W = 64;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    CAP
  } pad_state_e;

  localparam logic [7:0] SHA3_DS = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

endpackage

// File: rtl/kpad_lane_fmt.sv
// Combinational lane builder: passes message words through, or forms pad10*1 /
// capacity lanes from the byte count, pad flags and lane index.
module kpad_lane_fmt
  import keccak_pkg::*;
#(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DS_BYTE    = SHA3_DS
) (
  input  lane_t      word_i,
  input  logic [3:0] nbytes_i,
  input  logic       last_i,
  input  logic       genPad_i,
  input  logic       dsPending_i,
  input  logic       zero_i,
  input  logic [4:0] laneIdx_i,
  output lane_t      lane_o
);

  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);

  logic       rateEnd;
  logic [5:0] bitOfs;
  lane_t      keepMask;

  assign rateEnd  = (laneIdx_i == LAST_RATE);
  assign bitOfs   = {nbytes_i[2:0], 3'b000};
  assign keepMask = (lane_t'(1) << bitOfs) - lane_t'(1);

  // A partial last word keeps its low bytes and gets the domain byte right above them.
  always_comb begin
    lane_o = '0;
    if (zero_i) begin
      lane_o = '0;
    end else if (genPad_i) begin
      lane_o[7:0] = dsPending_i ? DS_BYTE : 8'h00;
      if (rateEnd) lane_o[63:56] = lane_o[63:56] | PAD_END;
    end else if (!last_i || nbytes_i[3]) begin
      lane_o = word_i;
    end else begin
      lane_o = (word_i & keepMask) | (lane_t'(DS_BYTE) << bitOfs);
      if (rateEnd) lane_o[63:56] = lane_o[63:56] | PAD_END;
    end
  end

endmodule

// File: rtl/keccak_pad_blk.sv
// Packs message words into 25-lane Keccak blocks with SHA-3 padding, streamed x-fast.
// Optional block counter output blkcnt is enabled by defining KPAD_STATS_EN.
module keccak_pad_blk
  import keccak_pkg::*;
#(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DS_BYTE    = SHA3_DS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  output logic        stopin,
  input  logic        firstin,
  input  logic        lastin,
  input  logic [3:0]  nbytes,
  input  logic [63:0] din,
  output logic        pushout,
  input  logic        stopout,
  output logic        firstout,
  output logic [63:0] dout
`ifdef KPAD_STATS_EN
  ,
  output logic [15:0] blkcnt
`endif
);

  localparam logic [4:0] LAST_RATE = 5'(RATE_LANES - 1);
  localparam logic [4:0] LAST_LANE = 5'(NLANES - 1);

  pad_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       padPending_q, padPending_d;
  logic       msgOpen_q, msgOpen_d;
  logic       holdValid_q, holdValid_d;
  lane_t      holdWord_q, holdWord_d;
  logic       holdLast_q, holdLast_d;
  logic [3:0] holdNb_q, holdNb_d;
  logic       pushout_q, pushout_d;
  logic       firstout_q, firstout_d;
  lane_t      dout_q, dout_d;

  logic       ready;
  logic       accept;
  logic       useHold;
  lane_t      srcWord;
  logic [3:0] srcNb;
  logic       srcLast;
  lane_t      lane;
  logic       procWord;
  logic       procFirst;

  assign ready   = !pushout_q || !stopout;
  assign stopin  = (pushout_q && stopout) || (state_q == PAD) || (state_q == CAP);
  assign accept  = pushin && !stopin;
  // A firstin word that interrupted an open message is replayed as lane 0 once the old block closes.
  assign useHold = (state_q == CAP) && holdValid_q && (cnt_q == 5'd0);
  assign srcWord = useHold ? holdWord_q : din;
  assign srcNb   = useHold ? holdNb_q   : nbytes;
  assign srcLast = useHold ? holdLast_q : lastin;

  kpad_lane_fmt #(
    .RATE_LANES(RATE_LANES),
    .DS_BYTE   (DS_BYTE)
  ) u_fmt (
    .word_i     (srcWord),
    .nbytes_i   (srcNb),
    .last_i     (srcLast),
    .genPad_i   (state_q == PAD),
    .dsPending_i(padPending_q),
    .zero_i     ((state_q == CAP) && !useHold),
    .laneIdx_i  (cnt_q),
    .lane_o     (lane)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    padPending_d = padPending_q;
    msgOpen_d    = msgOpen_q;
    holdValid_d  = holdValid_q;
    holdWord_d   = holdWord_q;
    holdLast_d   = holdLast_q;
    holdNb_d     = holdNb_q;
    pushout_d    = pushout_q;
    firstout_d   = firstout_q;
    dout_d       = dout_q;
    procWord     = 1'b0;
    procFirst    = 1'b0;

    if (ready) begin
      pushout_d  = 1'b0;
      firstout_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept && firstin) begin
          procWord  = 1'b1;
          procFirst = 1'b1;
        end
      end
      DATA: begin
        if (accept) begin
          if (firstin && (cnt_q != 5'd0)) begin
            holdValid_d = 1'b1;
            holdWord_d  = din;
            holdLast_d  = lastin;
            holdNb_d    = nbytes;
            msgOpen_d   = 1'b0;
            state_d     = CAP;
          end else begin
            procWord  = 1'b1;
            procFirst = firstin;
          end
        end
      end
      PAD: begin
        if (ready) begin
          pushout_d    = 1'b1;
          dout_d       = lane;
          padPending_d = 1'b0;
          cnt_d        = cnt_q + 5'd1;
          if (cnt_q == LAST_RATE) state_d = CAP;
        end
      end
      CAP: begin
        if (ready) begin
          if (useHold) begin
            procWord    = 1'b1;
            procFirst   = 1'b1;
            holdValid_d = 1'b0;
          end else begin
            pushout_d = 1'b1;
            dout_d    = lane;
            if (cnt_q == LAST_LANE) begin
              cnt_d = 5'd0;
              if (holdValid_q)       state_d = CAP;
              else if (padPending_q) state_d = PAD;
              else if (msgOpen_q)    state_d = DATA;
              else                   state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 5'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (procWord) begin
      pushout_d  = 1'b1;
      dout_d     = lane;
      firstout_d = procFirst && (cnt_q == 5'd0);
      cnt_d      = cnt_q + 5'd1;
      msgOpen_d  = !srcLast;
      if (srcLast) padPending_d = srcNb[3];
      if (cnt_q == LAST_RATE) state_d = CAP;
      else                    state_d = srcLast ? PAD : DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 5'd0;
      padPending_q <= 1'b0;
      msgOpen_q    <= 1'b0;
      holdValid_q  <= 1'b0;
      holdWord_q   <= '0;
      holdLast_q   <= 1'b0;
      holdNb_q     <= 4'd0;
      pushout_q    <= 1'b0;
      firstout_q   <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      padPending_q <= padPending_d;
      msgOpen_q    <= msgOpen_d;
      holdValid_q  <= holdValid_d;
      holdWord_q   <= holdWord_d;
      holdLast_q   <= holdLast_d;
      holdNb_q     <= holdNb_d;
      pushout_q    <= pushout_d;
      firstout_q   <= firstout_d;
      dout_q       <= dout_d;
    end
  end

  assign pushout  = pushout_q;
  assign firstout = firstout_q;
  assign dout     = dout_q;

`ifdef KPAD_STATS_EN
  logic        lastOut_q;
  logic [15:0] blkcnt_q;

  // The output register tracks whether it holds lane 24 so blocks count on downstream transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lastOut_q <= 1'b0;
      blkcnt_q  <= 16'd0;
    end else begin
      if (ready) lastOut_q <= (state_q == CAP) && !useHold && (cnt_q == LAST_LANE);
      if (pushout_q && !stopout && lastOut_q) blkcnt_q <= blkcnt_q + 16'd1;
    end
  end

  assign blkcnt = blkcnt_q;
`endif

endmodule

// File: tb/tb_keccak_pad_blk.sv
// Randomized self-checking bench for keccak_pad_blk against a byte-level SHA-3 padding model.
module tb_keccak_pad_blk;
  import keccak_pkg::*;

  localparam int R = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pushin = 1'b0;
  logic        firstin = 1'b0;
  logic        lastin = 1'b0;
  logic [3:0]  nbytes = 4'd0;
  logic [63:0] din = 64'd0;
  logic        stopout = 1'b0;
  logic        stopin;
  logic        pushout;
  logic        firstout;
  logic [63:0] dout;
`ifdef KPAD_STATS_EN
  logic [15:0] blkcnt;
`endif

  int errors = 0;
  int checks = 0;
  int xferCount = 0;
  int xferAtReset = 0;
  bit stopRandom = 0;
  bit gapsOn = 0;
  logic [64:0] expQ[$];
  logic [64:0] pinLanes[$];
  logic [7:0]  msgBytes[$];
  logic [63:0] rstWords[11];

  keccak_pad_blk dut (
    .clk     (clk),
    .rst     (rst),
    .pushin  (pushin),
    .stopin  (stopin),
    .firstin (firstin),
    .lastin  (lastin),
    .nbytes  (nbytes),
    .din     (din),
    .pushout (pushout),
    .stopout (stopout),
    .firstout(firstout),
`ifdef KPAD_STATS_EN
    .blkcnt  (blkcnt),
`endif
    .dout    (dout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-level pad10*1: append DS, zero-fill to whole rate blocks, set the top bit of the last rate byte.
  task automatic modelComplete(input logic [7:0] msg[$], output logic [64:0] lanes[$]);
    int L, nblk, tot;
    logic [7:0] padded[];
    logic [63:0] lv;
    L    = msg.size();
    nblk = L / (8 * R) + 1;
    tot  = nblk * 8 * R;
    padded = new[tot];
    for (int i = 0; i < tot; i++) padded[i] = (i < L) ? msg[i] : 8'h00;
    padded[L]     = SHA3_DS;
    padded[tot-1] = padded[tot-1] | PAD_END;
    lanes = {};
    for (int b = 0; b < nblk; b++)
      for (int j = 0; j < NLANES; j++) begin
        lv = 64'd0;
        if (j < R)
          for (int k = 0; k < 8; k++) lv[8*k +: 8] = padded[(b*R + j)*8 + k];
        lanes.push_back({(b == 0 && j == 0), lv});
      end
  endtask

  task automatic modelAbort(input logic [63:0] words[$], output logic [64:0] lanes[$]);
    int n, nblk;
    n    = words.size();
    nblk = (n + R - 1) / R;
    lanes = {};
    for (int b = 0; b < nblk; b++)
      for (int j = 0; j < NLANES; j++)
        lanes.push_back({(b == 0 && j == 0), ((j < R) && (b*R + j < n)) ? words[b*R + j] : 64'd0});
  endtask

  task automatic applyStimulus(input logic [63:0] w, input bit f, input bit l, input logic [3:0] nb);
    bit done;
    int waited;
    done = 0;
    waited = 0;
    if (gapsOn && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    while (!done) begin
      @(negedge clk);
      pushin = 1'b1; din = w; firstin = f; lastin = l; nbytes = nb;
      #4;
      if (!stopin) done = 1;
      @(posedge clk);
      if (!done) begin
        waited++;
        if (waited > 3000) begin
          checks++; errors++;
          $display("[TB] FAIL accept timeout: got stopin=%b expected 0 within 3000 cycles", stopin);
          done = 1;
        end
      end
    end
    #1;
    pushin = 1'b0; firstin = 1'b0; lastin = 1'b0;
  endtask

  task automatic sendComplete(input logic [7:0] msg[$], input bit extraEmpty);
    int L, nw;
    logic [63:0] w;
    logic [64:0] lanes[$];
    L  = msg.size();
    nw = (L == 0) ? 1 : (L + 7) / 8;
    if (extraEmpty && L > 0 && (L % 8) == 0) nw++;
    modelComplete(msg, lanes);
    foreach (lanes[i]) expQ.push_back(lanes[i]);
    for (int i = 0; i < nw; i++) begin
      w = {$urandom, $urandom};
      for (int k = 0; k < 8; k++)
        if (8*i + k < L) w[8*k +: 8] = msg[8*i + k];
      applyStimulus(w, (i == 0), (i == nw - 1), (i == nw - 1) ? 4'(L - 8*(nw - 1)) : 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic sendAbort(input int n);
    logic [63:0] words[$];
    logic [64:0] lanes[$];
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
    modelAbort(words, lanes);
    foreach (lanes[i]) expQ.push_back(lanes[i]);
    for (int i = 0; i < n; i++) applyStimulus(words[i], (i == 0), 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic randomMsg(input int L, output logic [7:0] msg[$]);
    msg = {};
    for (int i = 0; i < L; i++) msg.push_back(8'($urandom));
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while ((expQ.size() != 0 || pushout) && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 5000) begin
      checks++; errors++;
      $display("[TB] FAIL drain timeout: got %0d lanes outstanding expected 0", expQ.size());
    end
  endtask

  always begin
    @(negedge clk);
    if (stopRandom) stopout = ($urandom_range(0, 3) == 0);
  end

  // Compare process: every downstream transfer is matched against the model queue in order.
  logic [63:0] prevDout;
  logic        prevFirst;
  bit          prevStall = 0;
  always begin
    logic [64:0] e;
    @(negedge clk);
    #4;
    if (rst === 1'b0) begin
      prevStall = 0;
    end else begin
      if (prevStall) begin
        checkOutput("hold pushout", 64'(pushout), 64'd1);
        checkOutput("hold dout", dout, prevDout);
        checkOutput("hold firstout", 64'(firstout), 64'(prevFirst));
      end
      if (pushout && stopout) checkOutput("stopin under stall", 64'(stopin), 64'd1);
      if (pushout && !stopout) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected lane: got %h expected no lane", dout);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("lane %0d data", xferCount), dout, e[63:0]);
          checkOutput($sformatf("lane %0d firstout", xferCount), 64'(firstout), 64'(e[64]));
        end
        xferCount++;
      end
      prevStall = pushout && stopout;
      prevDout  = dout;
      prevFirst = firstout;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 90000 cycles");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    logic [7:0] abc[$];

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #4;
    checkOutput("reset pushout", 64'(pushout), 64'd0);
    checkOutput("reset firstout", 64'(firstout), 64'd0);
    checkOutput("reset dout", dout, 64'd0);
    checkOutput("reset stopin", 64'(stopin), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Hand-computed expectations pinning the model.
    msgBytes = {};
    modelComplete(msgBytes, pinLanes);
    checkOutput("model empty count", 64'(pinLanes.size()), 64'd25);
    checkOutput("model empty lane0", pinLanes[0][63:0], 64'h06);
    checkOutput("model empty lane16", pinLanes[16][63:0], 64'h8000_0000_0000_0000);
    checkOutput("model empty first", 64'(pinLanes[0][64]), 64'd1);
    abc = {8'h61, 8'h62, 8'h63};
    modelComplete(abc, pinLanes);
    checkOutput("model abc lane0", pinLanes[0][63:0], 64'h0000_0000_0663_6261);
    checkOutput("model abc lane16", pinLanes[16][63:0], 64'h8000_0000_0000_0000);
    randomMsg(135, msgBytes);
    modelComplete(msgBytes, pinLanes);
    checkOutput("model 135 count", 64'(pinLanes.size()), 64'd25);
    checkOutput("model 135 top byte", 64'(pinLanes[16][63:56]), 64'h86);
    checkOutput("model 135 low byte", 64'(pinLanes[16][7:0]), 64'(msgBytes[128]));
    randomMsg(136, msgBytes);
    modelComplete(msgBytes, pinLanes);
    checkOutput("model 136 count", 64'(pinLanes.size()), 64'd50);
    checkOutput("model 136 lane25", 64'(pinLanes[25]), 64'h06);
    checkOutput("model 136 lane41", 64'(pinLanes[41]), 64'h8000_0000_0000_0000);

    stopRandom = 0;
    stopout = 1'b0;

    msgBytes = {};
    sendComplete(msgBytes, 0);
    waitDrain();

    modelComplete(abc, pinLanes);
    foreach (pinLanes[i]) expQ.push_back(pinLanes[i]);
    applyStimulus(64'hFFFF_FFFF_FF63_6261, 1'b1, 1'b1, 4'd3);
    checkOutput("abc latency pushout", 64'(pushout), 64'd1);
    checkOutput("abc latency dout", dout, 64'h0000_0000_0663_6261);
    checkOutput("abc latency firstout", 64'(firstout), 64'd1);
    waitDrain();

    randomMsg(135, msgBytes); sendComplete(msgBytes, 0); waitDrain();
    randomMsg(136, msgBytes); sendComplete(msgBytes, 0); waitDrain();
    randomMsg(136, msgBytes); sendComplete(msgBytes, 1); waitDrain();

    sendAbort(5);
    sendComplete(abc, 0);
    waitDrain();
    sendAbort(17);
    randomMsg(20, msgBytes); sendComplete(msgBytes, 0);
    waitDrain();

    applyStimulus({$urandom, $urandom}, 1'b0, 1'b0, 4'd8);
    randomMsg(9, msgBytes); sendComplete(msgBytes, 0);
    waitDrain();

    // Stall five cycles around lane 10 of a two-block message.
    randomMsg(160, msgBytes);
    fork
      sendComplete(msgBytes, 0);
      begin
        c = xferCount + 10;
        while (xferCount < c) @(posedge clk);
        @(negedge clk);
        stopout = 1'b1;
        #4;
        checkOutput("stall lane present", 64'(pushout), 64'd1);
        repeat (5) @(negedge clk);
        stopout = 1'b0;
      end
    join
    waitDrain();

    // Reset while lane 10 sits in the output register.
    for (int i = 0; i < 11; i++) rstWords[i] = {$urandom, $urandom};
    for (int i = 0; i < 10; i++) expQ.push_back({(i == 0), rstWords[i]});
    for (int i = 0; i < 11; i++) applyStimulus(rstWords[i], (i == 0), 1'b0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    xferAtReset = xferCount;
    @(negedge clk); #4;
    checkOutput("pushout after reset", 64'(pushout), 64'd0);
    checkOutput("lanes before reset", 64'(expQ.size()), 64'd0);
    expQ.delete();
    sendComplete(abc, 0);
    waitDrain();

    stopRandom = 1;
    gapsOn = 1;
    for (int m = 0; m < 30; m++) begin
      if ($urandom_range(0, 4) == 0) applyStimulus({$urandom, $urandom}, 1'b0, 1'b1, 4'd3);
      if ($urandom_range(0, 3) == 0) sendAbort($urandom_range(1, 40));
      randomMsg($urandom_range(0, 300), msgBytes);
      sendComplete(msgBytes, $urandom_range(0, 1));
    end
    waitDrain();
    stopRandom = 0;
    gapsOn = 0;
    @(negedge clk);
    stopout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final queue empty", 64'(expQ.size()), 64'd0);
    checkOutput("final pushout idle", 64'(pushout), 64'd0);
`ifdef KPAD_STATS_EN
    checkOutput("block count", 64'(blkcnt), 64'((xferCount - xferAtReset) / 25));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
